// File: rtl/gate_tt_checker.sv
// Exhaustive truth-table sweep/checker for a 2^N_IN-row gate; GATE_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
// Latency: done rises 2^N_IN*(SETTLE_CYC+1) edges after the start edge; start is ignored while busy (no backpressure otherwise).
module gate_tt_checker #(
  parameter int                       N_IN       = 2,
  parameter logic [(1<<N_IN)-1:0]     EXPECT_TT  = 4'b0111,
  parameter int                       SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  localparam int         NV          = 1 << N_IN;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [N_IN:0] VEC_LAST = (N_IN+1)'(NV - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state_q;
  logic [N_IN:0]   vec_q;
  logic [3:0]      cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] ffv_q;
  logic            ffvld_q;

  logic            mismatch;
  logic            last_vec;
  logic            stop_early;
  logic [N_IN:0]   err_d;

  assign mismatch = (dut_out != EXPECT_TT[vec_q[N_IN-1:0]]);
  assign last_vec = (vec_q == VEC_LAST);
  assign err_d    = err_q + (N_IN+1)'(mismatch);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
          end
        end
        DRIVE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_q <= err_d;
          if (mismatch && !ffvld_q) begin
            ffv_q   <= vec_q[N_IN-1:0];
            ffvld_q <= 1'b1;
          end
          // dut_in is a view of vec_q, so leaving vec_q alone holds the last/failing vector in DONE
          if (last_vec || stop_early) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_q + (N_IN+1)'(1);
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_in           = vec_q[N_IN-1:0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvld_q;

endmodule
